dmem_arbiter: RTL and testbench

//  Shares the single-port data memory (1-cycle registered read, en/we/addr/wdata/rdata) between
//  two requesters: port 0 = OoO load/store unit (priority), port 1 = loader/debug port.
//  Per port: valid/ready request channel plus a per-port response channel with backpressure.

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_rsp_slot.sv | 64 ++++++
 rtl/dmem_arbiter.sv | 100 ++++++++++
 tb/tb_dmem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: response slot states and default widths.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_ADDR_W       = 14;
  localparam int unsigned DMEM_DATA_W       = 32;
  localparam int unsigned DMEM_STARVE_LIMIT = 8;
  localparam int unsigned DMEM_CNT_W        = 4;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_INFL = 2'd1,
    SLOT_HELD = 2'd2
  } slot_state_t;

endpackage

// File: rtl/dmem_rsp_slot.sv
// Per-port read response slot: tracks the single outstanding read and holds its data
// when the consumer back-pressures.
module dmem_rsp_slot
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_grant,
  input  logic              rsp_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  slot_state_t       state;
  slot_state_t       state_nxt;
  logic              capture;
  logic [DATA_W-1:0] hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SLOT_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          hold <= '0;
    else if (capture) hold <= mem_rdata;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    unique case (state)
      SLOT_IDLE: begin
        if (rd_grant) state_nxt = SLOT_INFL;
      end
      SLOT_INFL: begin
        rsp_valid = 1'b1;
        rsp_rdata = mem_rdata;
        if (rsp_ready) begin
          state_nxt = rd_grant ? SLOT_INFL : SLOT_IDLE;
        end else begin
          // memory output is only valid for one cycle, so park it
          capture   = 1'b1;
          state_nxt = SLOT_HELD;
        end
      end
      SLOT_HELD: begin
        rsp_valid = 1'b1;
        rsp_rdata = hold;
        if (rsp_ready) state_nxt = rd_grant ? SLOT_INFL : SLOT_IDLE;
      end
      default: state_nxt = SLOT_IDLE;
    endcase
  end

  assign busy = (state != SLOT_IDLE);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: LSU (port 0) has priority, the
// loader/debug port (port 1) is protected from starvation by a wait counter.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = DMEM_ADDR_W,
  parameter int unsigned DATA_W       = DMEM_DATA_W,
  parameter int unsigned STARVE_LIMIT = DMEM_STARVE_LIMIT,
  parameter int unsigned CNT_W        = DMEM_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_rsp_valid,
  input  logic              p0_rsp_ready,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_rsp_valid,
  input  logic              p1_rsp_ready,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             busy0;
  logic             busy1;
  logic             elig0;
  logic             elig1;
  logic             grant0;
  logic             grant1;
  logic [CNT_W-1:0] starve_cnt;

  // a read may only issue when its slot can take the response next cycle
  assign elig0 = p0_req_we | ~busy0 | p0_rsp_ready;
  assign elig1 = p1_req_we | ~busy1 | p1_rsp_ready;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (p1_req_valid && elig1 && starve_cnt == LIMIT) grant1 = 1'b1;
      else if (p0_req_valid && elig0)                   grant0 = 1'b1;
      else if (p1_req_valid && elig1)                   grant1 = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant1 || !p1_req_valid) begin
      starve_cnt <= '0;
    end else if (elig1 && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign p0_req_ready = grant0;
  assign p1_req_ready = grant1;

  assign mem_addr  = grant1 ? p1_req_addr  : p0_req_addr;
  assign mem_wdata = grant1 ? p1_req_wdata : p0_req_wdata;
  assign mem_we    = (grant0 & p0_req_we)  | (grant1 & p1_req_we);
  assign mem_en    = (grant0 & ~p0_req_we) | (grant1 & ~p1_req_we);

  dmem_rsp_slot #(.DATA_W(DATA_W)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .rd_grant  (grant0 & ~p0_req_we),
    .rsp_ready (p0_rsp_ready),
    .mem_rdata (mem_rdata),
    .rsp_valid (p0_rsp_valid),
    .rsp_rdata (p0_rsp_rdata),
    .busy      (busy0)
  );

  dmem_rsp_slot #(.DATA_W(DATA_W)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .rd_grant  (grant1 & ~p1_req_we),
    .rsp_ready (p1_rsp_ready),
    .mem_rdata (mem_rdata),
    .rsp_valid (p1_rsp_valid),
    .rsp_rdata (p1_rsp_rdata),
    .busy      (busy1)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level reference (pending-response flags, shadow memory, wait counter).
module tb_dmem_arbiter;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 16384;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid, p0_rsp_ready;
  logic [AW-1:0] p0_req_addr;
  logic [DW-1:0] p0_req_wdata, p0_rsp_rdata;
  logic          p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid, p1_rsp_ready;
  logic [AW-1:0] p1_req_addr;
  logic [DW-1:0] p1_req_wdata, p1_rsp_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  int unsigned checks = 0;
  int unsigned passes = 0;

  bit            m_has  [2];
  logic [DW-1:0] m_data [2];
  int unsigned   m_wait = 0;
  logic          obs_g1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .p0_req_valid (p0_req_valid),
    .p0_req_ready (p0_req_ready),
    .p0_req_we    (p0_req_we),
    .p0_req_addr  (p0_req_addr),
    .p0_req_wdata (p0_req_wdata),
    .p0_rsp_valid (p0_rsp_valid),
    .p0_rsp_ready (p0_rsp_ready),
    .p0_rsp_rdata (p0_rsp_rdata),
    .p1_req_valid (p1_req_valid),
    .p1_req_ready (p1_req_ready),
    .p1_req_we    (p1_req_we),
    .p1_req_addr  (p1_req_addr),
    .p1_req_wdata (p1_req_wdata),
    .p1_rsp_valid (p1_rsp_valid),
    .p1_rsp_ready (p1_rsp_ready),
    .p1_rsp_rdata (p1_rsp_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passes++;
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    bit e0, e1, g0, g1;
    #1;
    if (rst) begin
      m_has[0] = 1'b0;
      m_has[1] = 1'b0;
      m_wait   = 0;
    end
    check("p0_rsp_valid", 32'(p0_rsp_valid), 32'(m_has[0]));
    if (m_has[0]) check("p0_rsp_rdata", p0_rsp_rdata, m_data[0]);
    check("p1_rsp_valid", 32'(p1_rsp_valid), 32'(m_has[1]));
    if (m_has[1]) check("p1_rsp_rdata", p1_rsp_rdata, m_data[1]);

    e0 = p0_req_we || !m_has[0] || p0_rsp_ready;
    e1 = p1_req_we || !m_has[1] || p1_rsp_ready;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (p1_req_valid && e1 && m_wait >= 8) g1 = 1'b1;
      else if (p0_req_valid && e0)           g0 = 1'b1;
      else if (p1_req_valid && e1)           g1 = 1'b1;
    end
    obs_g1 = p1_req_ready;
    check("p0_req_ready", 32'(p0_req_ready), 32'(g0));
    check("p1_req_ready", 32'(p1_req_ready), 32'(g1));
    check("mem_en", 32'(mem_en), 32'((g0 && !p0_req_we) || (g1 && !p1_req_we)));
    check("mem_we", 32'(mem_we), 32'((g0 && p0_req_we) || (g1 && p1_req_we)));
    if (g0 || g1) check("mem_addr", 32'(mem_addr), 32'(g1 ? p1_req_addr : p0_req_addr));
    if ((g0 && p0_req_we) || (g1 && p1_req_we))
      check("mem_wdata", mem_wdata, g1 ? p1_req_wdata : p0_req_wdata);

    if (m_has[0] && p0_rsp_ready) m_has[0] = 1'b0;
    if (m_has[1] && p1_rsp_ready) m_has[1] = 1'b0;
    if (g0) begin
      if (p0_req_we) ref_mem[p0_req_addr] = p0_req_wdata;
      else begin m_has[0] = 1'b1; m_data[0] = ref_mem[p0_req_addr]; end
    end
    if (g1) begin
      if (p1_req_we) ref_mem[p1_req_addr] = p1_req_wdata;
      else begin m_has[1] = 1'b1; m_data[1] = ref_mem[p1_req_addr]; end
    end
    if (rst || g1 || !p1_req_valid) m_wait = 0;
    else if (e1 && m_wait < 8)      m_wait++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = '0; p0_req_wdata = '0; p0_rsp_ready = 1'b1;
    p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = '0; p1_req_wdata = '0; p1_rsp_ready = 1'b1;
  endtask

  task automatic drive0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d;
  endtask

  initial begin
    int unsigned waited;
    bit          got;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = 32'(i) * 32'h9E37_79B1;
      ref_mem[i] = 32'(i) * 32'h9E37_79B1;
    end
    mem[16'h0010] = 32'hDEAD_BEEF; ref_mem[16'h0010] = 32'hDEAD_BEEF;
    mem[16'h0100] = 32'h1111_2222; ref_mem[16'h0100] = 32'h1111_2222;

    rst = 1'b1;
    idle_inputs();
    drive0(1'b1, 1'b0, 14'h0010, '0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();

    // plain read
    drive0(1'b1, 1'b0, 14'h0010, '0);
    tick();
    idle_inputs();
    tick();

    // write on p0 and read on p1 of the same word in the same cycle
    drive0(1'b1, 1'b1, 14'h0020, 32'hA5A5_A5A5);
    drive1(1'b1, 1'b0, 14'h0020, '0);
    tick();
    drive0(1'b0, 1'b0, '0, '0);
    tick();
    idle_inputs();
    tick();

    // p1 starved by a continuous p0 read stream, twice to show the counter restarts
    for (int rep = 0; rep < 2; rep++) begin
      idle_inputs();
      tick();
      drive1(1'b1, 1'b0, 14'h0030, '0);
      waited = 0;
      got    = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        drive0(1'b1, 1'b0, 14'($urandom_range(0, 15)), '0);
        tick();
        waited++;
        if (obs_g1) got = 1'b1;
      end
      check("starve_wait", waited, 9);
    end
    idle_inputs();
    tick();

    // p1 response back-pressured while p0 keeps reading
    drive1(1'b1, 1'b0, 14'h0100, '0);
    p1_rsp_ready = 1'b0;
    tick();
    drive1(1'b1, 1'b0, 14'h0104, '0);
    for (int k = 0; k < 5; k++) begin
      drive0(1'b1, 1'b0, 14'($urandom_range(0, 15)), '0);
      tick();
    end
    drive0(1'b0, 1'b0, '0, '0);
    p1_rsp_ready = 1'b1;
    tick();
    idle_inputs();
    tick();

    // top-address write then read
    drive0(1'b1, 1'b1, 14'h3FFF, 32'h1234_5678);
    tick();
    drive0(1'b1, 1'b0, 14'h3FFF, '0);
    tick();
    idle_inputs();
    tick();

    // reset while a p0 read is in flight
    drive0(1'b1, 1'b0, 14'h0010, '0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    drive0(1'b1, 1'b0, 14'h0010, '0);
    tick();
    idle_inputs();
    tick();

    // random traffic over a small address window plus the top word
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 299) == 0);
      p0_req_valid = ($urandom_range(0, 9) < 6);
      p0_req_we    = ($urandom_range(0, 9) < 3);
      p0_req_addr  = ($urandom_range(0, 15) == 0) ? 14'h3FFF : 14'($urandom_range(0, 7));
      p0_req_wdata = $urandom;
      p0_rsp_ready = ($urandom_range(0, 9) < 7);
      p1_req_valid = ($urandom_range(0, 9) < 6);
      p1_req_we    = ($urandom_range(0, 9) < 3);
      p1_req_addr  = ($urandom_range(0, 15) == 0) ? 14'h3FFF : 14'($urandom_range(0, 7));
      p1_req_wdata = $urandom;
      p1_rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
